// File: rtl/rr_request_issuer.sv
// Consumer-side request issuer. It queues read/write commands and presents the head command to the
// round-robin scheduler, holding it until granted. It then tracks granted reads and forwards their data.
module rr_request_issuer #(
  parameter int ADDR_WIDTH      = 4,
  parameter int VALUE_WIDTH     = 8,
  parameter int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 1,
  parameter int DEPTH           = 4,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [VALUE_WIDTH-1:0] cmd_wdata,
  output logic [REQ_WIDTH-1:0]   req_word,
  output logic                   req_we,
  input  logic                   grant,
  input  logic                   rd_valid,
  input  logic [VALUE_WIDTH-1:0] rd_data,
  output logic                   resp_valid,
  output logic [VALUE_WIDTH-1:0] resp_data,
  output logic [15:0]            stall_count,
  output logic                   err_unexpected
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  if (REQ_WIDTH != ADDR_WIDTH + VALUE_WIDTH + 1) begin : g_bad_req_width
    $error("REQ_WIDTH must equal ADDR_WIDTH+VALUE_WIDTH+1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (READ_LATENCY < 1 || MAX_OUTSTANDING < 1) begin : g_bad_read_params
    $error("READ_LATENCY and MAX_OUTSTANDING must be at least 1");
  end

  logic                   mem_we    [DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_addr  [DEPTH];
  logic [VALUE_WIDTH-1:0] mem_wdata [DEPTH];

  logic [PTR_W:0]   wr_ptr, rd_ptr, count;
  logic [OUT_W-1:0] outstanding;
  logic             full, empty, push, pop, read_granted, rd_expected;
  logic             head_we, req_valid;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [VALUE_WIDTH-1:0] head_value;

  // Full uses the pointer wrap bit; empty uses the occupancy count.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (count == '0);

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign head_we    = mem_we[rd_ptr[PTR_W-1:0]];
  assign head_addr  = mem_addr[rd_ptr[PTR_W-1:0]];
  assign head_value = head_we ? mem_wdata[rd_ptr[PTR_W-1:0]] : '0;

  // A read at the head waits while the in-flight read budget is exhausted.
  assign req_valid = !empty && !(!head_we && (outstanding == OUT_MAX));
  assign req_word  = req_valid ? {1'b1, head_addr, head_value} : '0;
  assign req_we    = req_valid && head_we;

  assign pop          = grant && req_valid;
  assign read_granted = pop && !head_we;
  assign rd_expected  = rd_valid && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr[PTR_W-1:0]]    <= cmd_we;
      mem_addr[wr_ptr[PTR_W-1:0]]  <= cmd_addr;
      mem_wdata[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding    <= '0;
      err_unexpected <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      stall_count    <= '0;
    end else begin
      if (read_granted && !rd_expected)      outstanding <= outstanding + 1'b1;
      else if (!read_granted && rd_expected) outstanding <= outstanding - 1'b1;
      // Unexpected data is still forwarded; only the sticky flag records it.
      if (rd_valid && (outstanding == '0)) err_unexpected <= 1'b1;
      resp_valid <= rd_valid;
      resp_data  <= rd_data;
      if (req_valid && !grant && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rr_request_issuer.sv
// Directed bench for rr_request_issuer. A queue-based reference model is compared against the DUT on
// every cycle, and hand-computed literals at key points pin down the model.
module tb_rr_request_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [12:0] req_word;
  logic        req_we, grant, rd_valid;
  logic [7:0]  rd_data;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [15:0] stall_count;
  logic        err_unexpected;

  int n_checks = 0;
  int n_err    = 0;

  rr_request_issuer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_word(req_word), .req_we(req_we), .grant(grant),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .stall_count(stall_count), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  // Reference model: a command queue plus plain counters.
  cmd_t q[$];
  int   m_out;
  int   m_stall;
  bit   m_err;
  bit   m_resp_v;
  logic [7:0] m_resp_d;

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return !(!q[0].we && m_out == 4);
  endfunction

  function automatic logic [12:0] m_word();
    if (!m_valid()) return 13'h0;
    return {1'b1, q[0].addr, q[0].we ? q[0].data : 8'h00};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_out = 0; m_stall = 0; m_err = 0; m_resp_v = 0; m_resp_d = 8'h00;
    end else begin
      bit   v, do_pop, do_push;
      int   out_next;
      cmd_t c;
      v        = m_valid();
      do_pop   = grant && v;
      do_push  = cmd_valid && (q.size() < 4);
      out_next = m_out;
      if (rd_valid) begin
        if (m_out == 0) m_err = 1;
        else out_next = out_next - 1;
      end
      if (v && !grant && m_stall < 65535) m_stall++;
      if (do_pop) begin
        if (!q[0].we) out_next = out_next + 1;
        void'(q.pop_front());
      end
      if (do_push) begin
        c.we = cmd_we; c.addr = cmd_addr; c.data = cmd_wdata;
        q.push_back(c);
      end
      m_out    = out_next;
      m_resp_v = rd_valid;
      m_resp_d = rd_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model cmd_ready", 32'(cmd_ready), 32'(q.size() < 4));
    chk("model req_word", 32'(req_word), 32'(m_word()));
    chk("model req_we", 32'(req_we), 32'(m_valid() && q[0].we));
    chk("model resp_valid", 32'(resp_valid), 32'(m_resp_v));
    if (m_resp_v) chk("model resp_data", 32'(resp_data), 32'(m_resp_d));
    chk("model stall_count", 32'(stall_count), 32'(m_stall));
    chk("model err_unexpected", 32'(err_unexpected), 32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic we, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_word"}, 32'(req_word), 32'h0);
    chk({tag, " req_we"}, 32'(req_we), 32'h0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, " resp_data"}, 32'(resp_data), 32'h0);
    chk({tag, " stall_count"}, 32'(stall_count), 32'h0);
    chk({tag, " err"}, 32'(err_unexpected), 32'h0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0;
    grant = 0; rd_valid = 0; rd_data = 0;
    #1 reset = 1'b1;
    #2 chk_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Basic write
    set_cmd(1'b1, 4'h3, 8'hA5); step(); cmd_valid = 0;
    chk("wr req_word", 32'(req_word), 32'h13A5);
    chk("wr req_we", 32'(req_we), 32'h1);
    grant = 1; step(); grant = 0;
    chk("wr after grant", 32'(req_word), 32'h0);
    chk("wr req_we after", 32'(req_we), 32'h0);
    step();
    chk("wr no resp", 32'(resp_valid), 32'h0);

    // Read with latency 2
    set_cmd(1'b0, 4'h5, 8'h77); step(); cmd_valid = 0;
    chk("rd req_word", 32'(req_word), 32'h1500);
    chk("rd req_we", 32'(req_we), 32'h0);
    grant = 1; step(); grant = 0;
    chk("rd after grant", 32'(req_word), 32'h0);
    step();
    rd_valid = 1; rd_data = 8'h3C; step(); rd_valid = 0;
    chk("rd resp_valid", 32'(resp_valid), 32'h1);
    chk("rd resp_data", 32'(resp_data), 32'h3C);
    chk("rd no err", 32'(err_unexpected), 32'h0);
    step();
    chk("rd resp done", 32'(resp_valid), 32'h0);

    // Fill and backpressure; the 5th command stays offered through a grant while full
    for (int i = 1; i <= 4; i++) begin
      set_cmd(1'b1, 4'(i), 8'(8'h11 * i)); step();
    end
    chk("full cmd_ready", 32'(cmd_ready), 32'h0);
    chk("full head", 32'(req_word), 32'h1111);
    set_cmd(1'b1, 4'h5, 8'h55); step();
    chk("full still", 32'(cmd_ready), 32'h0);
    chk("full head held", 32'(req_word), 32'h1111);
    chk("full stall", 32'(stall_count), 32'd4);
    grant = 1; step(); grant = 0; cmd_valid = 0;
    chk("pop cmd_ready", 32'(cmd_ready), 32'h1);
    chk("pop next head", 32'(req_word), 32'h1222);
    grant = 1; step(); step(); step(); grant = 0;
    chk("5th dropped", 32'(req_word), 32'h0);
    chk("stall after drain", 32'(stall_count), 32'd4);

    // Outstanding limit
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b0, 4'(8 + i), 8'h00); step(); cmd_valid = 0;
      grant = 1; step(); grant = 0;
    end
    set_cmd(1'b0, 4'hC, 8'h00); step(); cmd_valid = 0;
    chk("limit valid", 32'(req_word), 32'h0);
    chk("limit req_we", 32'(req_we), 32'h0);
    grant = 1; step(); grant = 0;
    chk("limit grant ignored", 32'(req_word), 32'h0);
    chk("limit fifo kept", 32'(cmd_ready), 32'h1);
    chk("limit no stall", 32'(stall_count), 32'd4);
    rd_valid = 1; rd_data = 8'h81; step(); rd_valid = 0;
    chk("limit reenabled", 32'(req_word), 32'h1C00);
    chk("limit resp", 32'(resp_data), 32'h81);
    grant = 1; rd_valid = 1; rd_data = 8'h82; step(); grant = 0; rd_valid = 0;
    chk("simul popped", 32'(req_word), 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1; rd_data = 8'(8'h83 + i); step();
    end
    rd_valid = 0;
    chk("drain no err", 32'(err_unexpected), 32'h0);
    rd_valid = 1; rd_data = 8'hEE; step(); rd_valid = 0;
    chk("unexp err", 32'(err_unexpected), 32'h1);
    chk("unexp resp_valid", 32'(resp_valid), 32'h1);
    chk("unexp resp_data", 32'(resp_data), 32'hEE);

    // Push and pop together at count 2
    set_cmd(1'b1, 4'h1, 8'h10); step();
    set_cmd(1'b1, 4'h2, 8'h20); step();
    set_cmd(1'b1, 4'h3, 8'h30); grant = 1; step(); cmd_valid = 0; grant = 0;
    chk("pp head", 32'(req_word), 32'h1220);
    grant = 1; step();
    chk("pp second", 32'(req_word), 32'h1330);
    step(); grant = 0;
    chk("pp empty", 32'(req_word), 32'h0);
    chk("pp stall", 32'(stall_count), 32'd5);

    // Reset mid-stream, asserted away from any clock edge
    set_cmd(1'b1, 4'h4, 8'h40); step(); cmd_valid = 0; step();
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(posedge clk); #1 reset = 1'b0;
    rd_valid = 1; rd_data = 8'h99; step(); rd_valid = 0;
    chk("post reset err", 32'(err_unexpected), 32'h1);
    chk("post reset resp", 32'(resp_data), 32'h99);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_request_issuer.md
Name: rr_request_issuer

Overview:
- Consumer-side endpoint of the banked-memory request bus.
- Accepts read/write commands from one consumer into a FIFO and drives the head command onto that consumer's request word toward the round-robin scheduler.
- Holds each request until it is granted, then tracks granted reads and returns their data to the consumer in order.
- One instance per consumer; its req_word feeds one requests[] slot of the scheduler.

Parameters:
- ADDR_WIDTH, 4, memory address width.
- VALUE_WIDTH, 8, data width.
- REQ_WIDTH, ADDR_WIDTH+VALUE_WIDTH+1, request word width; derived, not overridden.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- READ_LATENCY, 2, cycles from a granted read to rd_valid from the memory; at least 1.
- MAX_OUTSTANDING, 4, limit on granted reads still awaiting data; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  consumer presents a command.
- cmd_ready  out  1  FIFO can accept; cmd_ready = !full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  VALUE_WIDTH  write data; ignored for reads.
- req_word  out  REQ_WIDTH  layout {valid, addr, value}; bit REQ_WIDTH-1 is valid.
- req_we  out  1  sideband write flag for the head command.
- grant  in  1  scheduler grants the presented request this cycle.
- rd_valid  in  1  memory read data valid.
- rd_data  in  VALUE_WIDTH  memory read data.
- resp_valid  out  1  read response to consumer, registered.
- resp_data  out  VALUE_WIDTH  read response data, registered.
- stall_count  out  16  saturating count of cycles with valid=1 and grant=0.
- err_unexpected  out  1  sticky; set by rd_valid with no read in flight.

Behaviour:
- Reset: FIFO empty, cmd_ready=1, req_word=0, req_we=0, resp_valid=0, resp_data=0, stall_count=0, outstanding=0, err_unexpected=0.
- FIFO: push when cmd_valid && cmd_ready. Wrap-around pointers, extra MSB for full/empty, count register.
- Push and pop in the same cycle are allowed, including when full: cmd_ready stays !full, so no push is accepted when full even if a pop occurs that cycle.
- Request drive (combinational from FIFO head):
  - valid = !empty && !(head is read && outstanding==MAX_OUTSTANDING).
  - addr and value come from the head; value = 0 for reads. req_we = head.we when valid, else 0.
- Request stability: while valid=1 and no grant, req_word and req_we hold constant. The head entry is not replaced.
- Grant: grant with valid=1 pops the head in the same cycle; the next head may be presented the following cycle.
  - Grant with valid=0 is ignored, FIFO untouched.
  - Writes complete at grant and produce no response.
- Read tracking:
  - A granted read increments outstanding. rd_valid decrements it.
  - Both in the same cycle leave outstanding unchanged.
  - Reads return in grant order, READ_LATENCY cycles after grant.
  - The block does not reorder; it trusts the memory's ordering.
- Response: resp_valid/resp_data register rd_valid/rd_data, so the consumer sees the data 1 cycle after rd_valid. There is no backpressure on responses.
- Unexpected data: rd_valid with outstanding==0 sets err_unexpected (sticky until reset). The data is still forwarded and outstanding stays 0, no underflow.
- stall_count: increments on each cycle with valid=1 and grant=0. Saturates at 16'hFFFF.
- Reset mid-operation: FIFO contents, in-flight reads and counters are discarded immediately. Data arriving after reset deassertion counts as unexpected.

Test Plan:
- Basic write: push we=1 addr=3 wdata=0xA5; grant on the next cycle.
  - Required: req_word = {1,4'h3,8'hA5}, req_we=1 before grant.
  - Required: req_word valid=0 after grant; no resp_valid.
- Read with latency 2: push read addr=5; grant at cycle T; drive rd_valid=1, rd_data=0x3C at T+2.
  - Required: resp_valid=1, resp_data=0x3C at T+3; outstanding returns to 0.
- Fill and backpressure: push 4 commands with grant held 0.
  - Required: cmd_ready=0 after the 4th push; the 5th cmd_valid is not accepted.
  - Required: the head word stays constant; stall_count counts those cycles.
  - Then grant 1 cycle: cmd_ready=1 and the next head appears.
- Outstanding limit: MAX_OUTSTANDING=4, grant 4 reads with no rd_valid.
  - Required: with a 5th read at the head, valid=0 even if grant=1, and FIFO unchanged.
  - One rd_valid re-enables valid on the next cycle.
- Simultaneous events: push and pop in the same cycle at count=2 leave count=2. Grant of a read together with rd_valid leaves outstanding unchanged.
- Error and reset: rd_valid with nothing in flight sets err_unexpected=1 and resp_valid=1 next cycle. Assert reset mid-stream: all outputs return to reset values asynchronously.
